// File: rtl/pc_sequencer_pkg.sv
// Shared datapath definitions for the PC sequencer: PC-select encodings and default step.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        PS_HOLD = 3'b000,
        PS_INC  = 3'b001,
        PS_ABS  = 3'b010,
        PS_REL  = 3'b011,
        PS_CALL = 3'b100,
        PS_RET  = 3'b101
    } ps_e;

    localparam int DEFAULT_STEP = 4;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module return_stack
    import pc_sequencer_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign ovf   = push && full;
    assign unf   = pop && empty;

    // ptr_q is the next write slot, so the top of stack sits just below it
    assign rdata = mem_q[ptr_q - PW'(1)];

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ptr_d = ptr_q + PW'(1);
            if (!full) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage keeps its contents across reset; only pointer and count clear
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with optional return-address stack (enabled by PC_SEQUENCER_RAS_EN).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int               WIDTH        = 64,
    parameter int               STEP         = DEFAULT_STEP,
    parameter int               RAS_DEPTH    = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       ps,
    input  logic             stall,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc4,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    logic [WIDTH-1:0] pc_q, pc_d;

    assign pc  = pc_q;
    assign pc4 = pc_q + WIDTH'(STEP);

`ifdef PC_SEQUENCER_RAS_EN
    logic             push, pop, ovf, unf;
    logic             err_q, err_d;
    logic [WIDTH-1:0] rdata;

    assign push  = !stall && (ps == PS_CALL);
    assign pop   = !stall && (ps == PS_RET);
    assign err_d = ovf | unf;

    return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_return_stack (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (pc4),
        .rdata (rdata),
        .empty (ras_empty),
        .full  (ras_full),
        .ovf   (ovf),
        .unf   (unf)
    );

    // Relative add relies on two's complement: a signed offset adds like an unsigned one
    always_comb begin
        pc_d = pc_q;
        case (ps)
            PS_INC:  pc_d = pc4;
            PS_ABS:  pc_d = in;
            PS_REL:  pc_d = pc_q + in;
            PS_CALL: pc_d = in;
            PS_RET:  pc_d = unf ? pc4 : rdata;
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ras_err = err_q;
`else
    always_comb begin
        pc_d = pc_q;
        case (ps)
            PS_INC:  pc_d = pc4;
            PS_ABS:  pc_d = in;
            PS_REL:  pc_d = pc_q + in;
            PS_CALL: pc_d = in;
            default: pc_d = pc_q;
        endcase
    end

    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_err   = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_VECTOR;
        end else if (!stall) begin
            pc_q <= pc_d;
        end
    end

endmodule
